fetch_stage: RTL and testbench

Instruction fetch stage feeding the decode/control unit. Owns the program counter, issues in-order word requests to instruction memory over a request/grant + response handshake, and buffers returned instructions with their PCs in a small FIFO. Presents one instruction per cycle to decode under valid/ready, pre-split into the fields the control unit consumes. Flushes and discards stale responses on a branch/jump redirect.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order instruction memory reads and
// buffers returned words with their PCs for the decode stage.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/addr/gnt              request channel to instruction memory
//   imem_rvalid/rdata              in-order response channel
//   redirect, redirect_pc          taken branch/jump: flush and restart
//   dec_valid/ready                handshake towards decode
//   dec_inst/pc/opcode/f3/f1       instruction and pre-split fields

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [6:0]  dec_opcode,
    output logic [2:0]  dec_f3,
    output logic        dec_f1
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0]  DEPTH_S = CW1'(DEPTH);
    localparam logic [31:0]  NOP     = 32'h0000_0013;

    typedef enum logic {
        FETCH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [31:0]    resp_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop_cnt;
    logic [CW-1:0]  count;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    entry_t         fifo [DEPTH];

    logic [CW:0]    credit_used;
    logic           grant;
    logic           dropping;
    logic           push;
    logic           pop;
    logic [CW-1:0]  out_next;
    logic [CW-1:0]  drop_next;
    logic [31:0]    redirect_base;
    entry_t         head;

    // A request is only issued when a FIFO slot is reserved for its
    // response, so the memory never sees backpressure.
    assign credit_used = {1'b0, outstanding} + {1'b0, count};
    assign imem_req    = (state == FETCH) & ~redirect & ~rst
                       & (credit_used < DEPTH_S);
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req & imem_gnt;

    assign dropping = (drop_cnt != '0);
    // A response landing in the redirect cycle is stale by definition.
    assign push     = imem_rvalid & ~dropping & ~redirect;
    assign pop      = dec_valid & dec_ready;

    assign out_next      = outstanding + CW'(grant) - CW'(imem_rvalid);
    assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        drop_next = drop_cnt;
        if (redirect)
            drop_next = out_next;
        else if (imem_rvalid & dropping)
            drop_next = drop_cnt - CW'(1);
    end

    assign head       = fifo[rd_ptr];
    assign dec_valid  = (count != '0) & ~rst;
    assign dec_inst   = dec_valid ? head.inst : NOP;
    assign dec_pc     = dec_valid ? head.pc : 32'h0;
    assign dec_opcode = dec_inst[6:0];
    assign dec_f3     = dec_inst[14:12];
    assign dec_f1     = dec_inst[30];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= out_next;
            drop_cnt    <= drop_next;
            if (redirect) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                state    <= (drop_next != '0) ? DRAIN : FETCH;
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + 32'd4;
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (state == DRAIN && drop_next == '0)
                    state <= FETCH;
            end
        end
    end

    // Payload storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push & ~rst)
            fifo[wr_ptr] <= '{pc: resp_pc, inst: imem_rdata};
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table vectors, directed redirect/reset sequences and a
// randomized run against a program-order reference model.

module tb_fetch_stage;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_f3;
    logic        dec_f1;

    fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_opcode(dec_opcode),
        .dec_f3(dec_f3), .dec_f1(dec_f1)
    );

    // Second instance: wrap-around reset PC, deeper FIFO, 1-cycle memory.
    logic        w_rst;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic        w_f1;

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
        .clk(clk), .rst(w_rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .dec_valid(w_valid), .dec_ready(w_ready),
        .dec_inst(w_inst), .dec_pc(w_pc), .dec_opcode(w_opcode),
        .dec_f3(w_f3), .dec_f1(w_f1)
    );

    always_ff @(posedge clk) begin
        if (w_rst) w_rvalid <= 1'b0;
        else       w_rvalid <= w_req & w_gnt;
        w_rdata <= w_addr;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory and reference model state
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        pend[$];
    int          cyc = 0;
    int          last_due = 0;
    int          epoch = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          n_deliv = 0;
    logic [31:0] mem_key = 32'h0;
    logic [31:0] fetch_exp = RST_PC;
    logic [31:0] deliver_exp = RST_PC;
    bit          prev_rd = 0;
    bit          kept_prev = 0;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ mem_key;
    endfunction

    // One clock cycle: drive inputs, sample, check, update the model.
    task automatic cycle(input bit g, input bit r, input bit rd,
                         input logic [31:0] rp);
        req_t        rsp;
        bit          rv;
        bit          grant;
        bit          accept;
        bit          kept;
        int          due;
        logic [31:0] ei;
        imem_gnt    = g;
        dec_ready   = r;
        redirect    = rd;
        redirect_pc = rp;
        rv = 0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            rsp = pend.pop_front();
            rv  = 1;
        end
        imem_rvalid = rv;
        imem_rdata  = rv ? memw(rsp.addr) : $urandom();
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = dec_valid;
        s_pc    = dec_pc;
        s_inst  = dec_inst;
        if (rst) begin
            chk("rst_req", 32'(imem_req), 32'(0));
            chk("rst_valid", 32'(dec_valid), 32'(0));
        end else begin
            if (rd) chk("redir_req", 32'(imem_req), 32'(0));
            if (imem_req) chk("req_addr", imem_addr, fetch_exp);
            if (prev_rd) chk("flush_valid", 32'(dec_valid), 32'(0));
            if (kept_prev) chk("resp_latency", 32'(dec_valid), 32'(1));
            chk("inflight", 32'(pend.size() <= DEPTH), 32'(1));
            if (dec_valid) begin
                ei = memw(deliver_exp);
                chk("dec_pc", dec_pc, deliver_exp);
                chk("dec_inst", dec_inst, ei);
                chk("dec_opcode", 32'(dec_opcode), 32'(ei[6:0]));
                chk("dec_f3", 32'(dec_f3), 32'(ei[14:12]));
                chk("dec_f1", 32'(dec_f1), 32'(ei[30]));
            end else begin
                chk("idle_inst", dec_inst, NOP);
                chk("idle_pc", dec_pc, 32'h0);
            end
        end
        grant  = !rst && imem_req && g;
        accept = !rst && dec_valid && r && !rd;
        kept   = rv && (rsp.epoch == epoch) && !rd;
        if (grant) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: imem_addr, due: due, epoch: epoch});
            fetch_exp += 32'd4;
        end
        if (accept) begin
            deliver_exp += 32'd4;
            n_deliv++;
        end
        if (rd) begin
            epoch++;
            fetch_exp   = rp & 32'hFFFF_FFFC;
            deliver_exp = rp & 32'hFFFF_FFFC;
        end
        if (rst) begin
            pend.delete();
            epoch++;
            fetch_exp   = RST_PC;
            deliver_exp = RST_PC;
            last_due    = cyc;
            kept        = 0;
        end
        prev_rd   = rd && !rst;
        kept_prev = kept;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(0, 0, 0, 32'h0);
        cycle(0, 0, 0, 32'h0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          r;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit eq, input logic [31:0] ea,
                       input bit ev, input logic [31:0] ep);
        tbl.push_back('{r: r, e_req: eq, e_addr: ea, e_valid: ev, e_pc: ep});
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect = 0; redirect_pc = 0; dec_ready = 0;
        w_rst = 1'b1; w_gnt = 1'b1; w_ready = 1'b1;
        w_redirect = 1'b0; w_redirect_pc = 32'h0;

        // 1-cycle memory, rdata = addr; 10-cycle decode stall; release
        add(1, 1, 32'h00, 0, 32'h00);
        add(1, 1, 32'h04, 0, 32'h00);
        add(1, 0, 32'h00, 1, 32'h00);
        add(1, 1, 32'h08, 1, 32'h04);
        add(1, 1, 32'h0C, 0, 32'h00);
        add(1, 0, 32'h00, 1, 32'h08);
        add(1, 1, 32'h10, 1, 32'h0C);
        add(0, 1, 32'h14, 0, 32'h00);
        for (int i = 0; i < 9; i++) add(0, 0, 32'h0, 1, 32'h10);
        add(1, 0, 32'h00, 1, 32'h10);
        add(1, 1, 32'h18, 1, 32'h14);
        add(1, 1, 32'h1C, 0, 32'h00);
        add(1, 0, 32'h00, 1, 32'h18);

        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(1, tbl[i].r, 0, 32'h0);
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req)
                chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid),
                32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
        end

        // Redirect to 0x100 with two requests in flight
        lat_lo = 3; lat_hi = 3;
        do_reset();
        cycle(1, 1, 0, 32'h0);
        chk("a_req0", 32'(s_req), 32'(1));
        cycle(1, 1, 0, 32'h0);
        chk("a_req1", 32'(s_req), 32'(1));
        chk("a_addr1", s_addr, 32'h4);
        cycle(1, 1, 1, 32'h100);
        chk("a_redir_req", 32'(s_req), 32'(0));
        cycle(1, 1, 0, 32'h0);
        chk("a_drain_valid", 32'(s_valid), 32'(0));
        chk("a_drain_nop", s_inst, NOP);
        chk("a_drain_req0", 32'(s_req), 32'(0));
        cycle(1, 1, 0, 32'h0);
        chk("a_drain_req1", 32'(s_req), 32'(0));
        cycle(1, 1, 0, 32'h0);
        chk("a_restart_req", 32'(s_req), 32'(1));
        chk("a_restart_addr", s_addr, 32'h100);
        repeat (3) cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 0, 32'h0);
        chk("a_first_valid", 32'(s_valid), 32'(1));
        chk("a_first_pc", s_pc, 32'h100);

        // Redirect to 0x203 in the same cycle as a response
        lat_lo = 2; lat_hi = 2;
        do_reset();
        cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 1, 32'h203);
        chk("b_redir_req", 32'(s_req), 32'(0));
        cycle(1, 1, 0, 32'h0);
        chk("b_drop_valid", 32'(s_valid), 32'(0));
        chk("b_drain_req", 32'(s_req), 32'(0));
        cycle(1, 1, 0, 32'h0);
        chk("b_restart_req", 32'(s_req), 32'(1));
        chk("b_restart_addr", s_addr, 32'h200);
        repeat (2) cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 0, 32'h0);
        chk("b_first_valid", 32'(s_valid), 32'(1));
        chk("b_first_pc", s_pc, 32'h200);

        // Reset with a full FIFO
        lat_lo = 1; lat_hi = 1;
        do_reset();
        repeat (6) cycle(1, 0, 0, 32'h0);
        chk("c_full_valid", 32'(s_valid), 32'(1));
        chk("c_full_pc", s_pc, 32'h0);
        rst = 1'b1;
        cycle(1, 1, 0, 32'h0);
        chk("c_rst_valid", 32'(s_valid), 32'(0));
        chk("c_rst_req", 32'(s_req), 32'(0));
        rst = 1'b0;
        cycle(1, 1, 0, 32'h0);
        chk("c_restart_req", 32'(s_req), 32'(1));
        chk("c_restart_addr", s_addr, RST_PC);
        cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 0, 32'h0);
        chk("c_first_pc", s_pc, RST_PC);

        // Randomized traffic
        mem_key = 32'h1357_9BDF;
        lat_lo = 1; lat_hi = 4;
        n_deliv = 0;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(599, 0) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
                      $urandom_range(39, 0) == 0, $urandom());
            end
        end
        chk("liveness", 32'(n_deliv > 200), 32'(1));

        // Wrap-around reset PC on the DEPTH=4 instance
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        w_rst       = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] e;
            if (k == 0) begin
                chk("w_req0", 32'(w_req), 32'(1));
                chk("w_addr0", w_addr, 32'hFFFF_FFF8);
            end
            if (k >= 2) begin
                e = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
                chk($sformatf("w_valid%0d", k), 32'(w_valid), 32'(1));
                chk($sformatf("w_pc%0d", k), w_pc, e);
                chk($sformatf("w_inst%0d", k), w_inst, e);
            end
            @(posedge clk);
            #2;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
